// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared defaults and request-slice packing for the tape-memory arbiter
// Holds the default core count, address/data widths and read latency. The
// select stage packs its register-file requests with the same widths.
package mem_arbiter_pkg;

  localparam int DEF_NCORES = 4;
  localparam int DEF_AW     = 16;
  localparam int DEF_DW     = 16;
  localparam int DEF_LAT    = 2;

  // One request slice is {we, addr, wdata}.
  function automatic int req_slice_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  localparam int REQ_SLICE_W = req_slice_w(DEF_AW, DEF_DW);

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core request/response and memory port bundle
// master: the arbiter view (takes requests and mem_rdata, drives grants,
//         responses and the memory port).
// slave:  the cores-plus-memory view, directions reversed.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) ();

  logic [NCORES-1:0]    req_valid;
  logic [NCORES-1:0]    req_we;
  logic [NCORES*AW-1:0] req_addr;
  logic [NCORES*DW-1:0] req_wdata;
  logic [NCORES-1:0]    req_ready;
  logic [NCORES-1:0]    rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin selector
// Ports: valid (request vector), ptr (highest-priority index),
//        grant (one-hot winner), idx (encoded winner), any (a winner exists).
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  // Scan ptr, ptr+1, ... modulo N; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter for the shared tape-memory port
// Ports: clk, rst (async, active high), bus (mem_arbiter_if.master):
//   req_valid/req_we/req_addr/req_wdata in, req_ready one-hot grant out,
//   rsp_valid one-hot + rsp_data read return, mem_en/mem_we/mem_addr/
//   mem_wdata memory access out, mem_rdata in (valid LAT cycles after a read).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int LAT    = DEF_LAT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int PW = $clog2(NCORES);
  localparam int SW = req_slice_w(AW, DW);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     idx;
  logic [NCORES-1:0] grant;
  logic              any;
  logic              live;
  logic              rd_grant;
  logic [SW-1:0]     sel;
  logic [NCORES-1:0] rsp;

  logic              pipe_v  [LAT];
  logic [PW-1:0]     pipe_id [LAT];

  rr_pick #(.N(NCORES), .PW(PW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // Grant is suppressed while reset is held, so nothing reaches memory.
  assign live = any & ~rst;

  // One-hot mux of the winning slice; all-zero when nothing is granted.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (!rst && grant[i]) begin
        sel = {bus.req_we[i], bus.req_addr[i*AW +: AW], bus.req_wdata[i*DW +: DW]};
      end
    end
  end

  assign rd_grant      = live & ~sel[SW-1];
  assign bus.req_ready = rst ? '0 : grant;
  assign bus.mem_en    = live;
  assign bus.mem_we    = sel[SW-1];
  assign bus.mem_addr  = sel[DW +: AW];
  assign bus.mem_wdata = sel[DW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (idx == PW'(NCORES - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Read tracker: each stage carries {valid, core id} one cycle further,
  // so the last stage lines up with mem_rdata for that read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_id[i] <= '0;
      end
    end else begin
      pipe_v[0]  <= rd_grant;
      pipe_id[0] <= rd_grant ? idx : '0;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  always_comb begin
    rsp = '0;
    if (pipe_v[LAT-1]) rsp[pipe_id[LAT-1]] = 1'b1;
  end

  assign bus.rsp_valid = rsp;
  assign bus.rsp_data  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  v   = '0;
  logic [3:0]  we  = '0;
  logic [63:0] addr  = '0;
  logic [63:0] wdata = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NCORES(4), .AW(16), .DW(16)) bus ();

  mem_arbiter #(.NCORES(4), .AW(16), .DW(16), .LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.req_valid = v;
  assign bus.req_we    = we;
  assign bus.req_addr  = addr;
  assign bus.req_wdata = wdata;

  // Memory model: cell a initially holds a ^ 16'hA5A5, two-cycle read latency.
  logic [15:0] mem [256];
  logic        mem_init = 1'b0;
  logic [15:0] rd_a = '0;
  logic [15:0] rd_b = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= 16'(a) ^ 16'hA5A5;
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            rd_a <= mem[bus.mem_addr[7:0]];
    end
    rd_b <= rd_a;
  end

  assign bus.mem_rdata = rd_b;

  localparam logic [63:0] ROT_ADDR = {16'h0040, 16'h0030, 16'h0020, 16'h0010};

  task automatic drive(input logic [3:0] dv, input logic [3:0] dwe,
                       input logic [63:0] da, input logic [63:0] dd);
    @(negedge clk);
    v = dv; we = dwe; addr = da; wdata = dd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v = '0; we = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 4'b1111; we = 4'b1111; addr = ROT_ADDR; wdata = 64'h1111_2222_3333_4444;
    @(negedge clk); @(negedge clk); #1;
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en got %b want 0", bus.mem_en); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", bus.mem_we); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b want 0000", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h want 0000", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'h0000) $display("FAIL reset_mem_wdata got %h want 0000", bus.mem_wdata); else n_pass++;
    @(negedge clk);
    rst = 1'b0; we = 4'b0000;
    #1;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL reset_first_grant got %b want 0001", bus.req_ready); else n_pass++;
    n_total++; if (bus.mem_addr !== 16'h0010) $display("FAIL reset_first_addr got %h want 0010", bus.mem_addr); else n_pass++;
  endtask

  task automatic test_rotation();
    logic [3:0]  exp_rdy;
    logic [15:0] exp_addr;
    logic [3:0]  exp_rv;
    logic [15:0] exp_rd;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive((k < 8) ? 4'b1111 : 4'b0000, 4'b0000, ROT_ADDR, 64'h0);
      exp_rdy  = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      exp_addr = (k < 8) ? 16'(16'h10 * (k % 4 + 1)) : 16'h0000;
      n_total++; if (bus.req_ready !== exp_rdy) $display("FAIL rot_grant[%0d] got %b want %b", k, bus.req_ready, exp_rdy); else n_pass++;
      n_total++; if (bus.mem_addr !== exp_addr) $display("FAIL rot_addr[%0d] got %h want %h", k, bus.mem_addr, exp_addr); else n_pass++;
      exp_rv = (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
      n_total++; if (bus.rsp_valid !== exp_rv) $display("FAIL rot_rsp_valid[%0d] got %b want %b", k, bus.rsp_valid, exp_rv); else n_pass++;
      if (k >= 2) begin
        exp_rd = 16'(16'h10 * ((k - 2) % 4 + 1)) ^ 16'hA5A5;
        n_total++; if (bus.rsp_data !== exp_rd) $display("FAIL rot_rsp_data[%0d] got %h want %h", k, bus.rsp_data, exp_rd); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    drive(4'b0100, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL wrap_setup got %b want 0100", bus.req_ready); else n_pass++;
    drive(4'b0101, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_skip0 got %b want 0001", bus.req_ready); else n_pass++;
    drive(4'b0101, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL wrap_skip1 got %b want 0100", bus.req_ready); else n_pass++;
    n_total++; if (bus.mem_addr !== 16'h0030) $display("FAIL wrap_skip1_addr got %h want 0030", bus.mem_addr); else n_pass++;
    drive(4'b0101, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_skip2 got %b want 0001", bus.req_ready); else n_pass++;
    // ptr=3 with a grant to core 3 must wrap to 0.
    do_reset();
    drive(4'b0100, 4'b0000, ROT_ADDR, 64'h0);
    drive(4'b1000, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL wrap_last got %b want 1000", bus.req_ready); else n_pass++;
    drive(4'b1111, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_to_zero got %b want 0001", bus.req_ready); else n_pass++;
  endtask

  task automatic test_write_read();
    do_reset();
    drive(4'b0010, 4'b0010, {16'h0, 16'h0, 16'h0005, 16'h0}, {16'h0, 16'h0, 16'h00AB, 16'h0});
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL wr_grant got %b want 0010", bus.req_ready); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b1) $display("FAIL wr_mem_we got %b want 1", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_addr !== 16'h0005) $display("FAIL wr_mem_addr got %h want 0005", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'h00AB) $display("FAIL wr_mem_wdata got %h want 00ab", bus.mem_wdata); else n_pass++;
    drive(4'b0100, 4'b0000, {16'h0, 16'h0005, 16'h0, 16'h0}, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL rd_grant got %b want 0100", bus.req_ready); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL rd_mem_we got %b want 0", bus.mem_we); else n_pass++;
    drive(4'b0001, 4'b0000, {16'h0, 16'h0, 16'h0, 16'h0007}, 64'h0);
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL wr_no_rsp got %b want 0000", bus.rsp_valid); else n_pass++;
    drive(4'b1000, 4'b1000, {16'h0007, 16'h0, 16'h0, 16'h0}, {16'h1234, 16'h0, 16'h0, 16'h0});
    n_total++; if (bus.rsp_valid !== 4'b0100) $display("FAIL raw_rsp_valid got %b want 0100", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 16'h00AB) $display("FAIL raw_rsp_data got %h want 00ab", bus.rsp_data); else n_pass++;
    drive(4'b0001, 4'b0000, {16'h0, 16'h0, 16'h0, 16'h0007}, 64'h0);
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL war_rsp_valid got %b want 0001", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 16'hA5A2) $display("FAIL war_old_data got %h want a5a2", bus.rsp_data); else n_pass++;
    drive(4'b0000, 4'b0000, 64'h0, 64'h0);
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL wr2_no_rsp got %b want 0000", bus.rsp_valid); else n_pass++;
    drive(4'b0000, 4'b0000, 64'h0, 64'h0);
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL raw2_rsp_valid got %b want 0001", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 16'h1234) $display("FAIL raw2_new_data got %h want 1234", bus.rsp_data); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    // Core 1 read moves ptr to 2; reset one cycle later must cancel it and clear ptr.
    drive(4'b0010, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL mid_grant1 got %b want 0010", bus.req_ready); else n_pass++;
    @(negedge clk); rst = 1'b1; v = '0;
    @(negedge clk); rst = 1'b0;
    drive(4'b1111, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL mid_ptr_cleared got %b want 0001", bus.req_ready); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL mid_rsp1_dropped got %b want 0000", bus.rsp_valid); else n_pass++;
    // ptr=1 now; core 3 read, reset the next cycle.
    drive(4'b1000, 4'b0000, ROT_ADDR, 64'h0);
    n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL mid_grant3 got %b want 1000", bus.req_ready); else n_pass++;
    @(negedge clk); rst = 1'b1; v = 4'b1111; we = 4'b1111;
    #1;
    n_total++; if (bus.req_ready !== 4'b0000) $display("FAIL mid_rst_ready got %b want 0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.mem_en !== 1'b0) $display("FAIL mid_rst_mem_en got %b want 0", bus.mem_en); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL mid_rst_mem_we got %b want 0", bus.mem_we); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL mid_rst_rsp got %b want 0000", bus.rsp_valid); else n_pass++;
    @(negedge clk); rst = 1'b0; v = '0; we = '0;
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, 4'b0000, 64'h0, 64'h0);
      n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL mid_no_rsp[%0d] got %b want 0000", k, bus.rsp_valid); else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [15:0] exp_rd;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive((k < 5) ? 4'b0100 : 4'b0000, 4'b0000, {16'h0, 16'(16'h50 + k), 16'h0, 16'h0}, 64'h0);
      n_total++; if (bus.req_ready !== ((k < 5) ? 4'b0100 : 4'b0000)) $display("FAIL single_grant[%0d] got %b", k, bus.req_ready); else n_pass++;
      if (k < 5) begin
        n_total++; if (bus.mem_addr !== 16'(16'h50 + k)) $display("FAIL single_addr[%0d] got %h want %h", k, bus.mem_addr, 16'(16'h50 + k)); else n_pass++;
      end
      if (k >= 2) begin
        exp_rd = 16'(16'h50 + k - 2) ^ 16'hA5A5;
        n_total++; if (bus.rsp_valid !== 4'b0100) $display("FAIL single_rsp_valid[%0d] got %b want 0100", k, bus.rsp_valid); else n_pass++;
        n_total++; if (bus.rsp_data !== exp_rd) $display("FAIL single_rsp_data[%0d] got %h want %h", k, bus.rsp_data, exp_rd); else n_pass++;
      end else begin
        n_total++; if (bus.rsp_valid !== 4'b0000) $display("FAIL single_rsp_idle[%0d] got %b want 0000", k, bus.rsp_valid); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_write_read();
    test_reset_midflight();
    test_single();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
